framebuffer_reader: RTL

// Reads the rectified WIDTH x HEIGHT frame written by the pixel transform out of
// the destination frame memory in raster order (addr = x + WIDTH*y, base 0) and

---
 rtl/framebuffer_reader_if.sv | 25 ++
 rtl/framebuffer_reader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/framebuffer_reader_if.sv
// Frame-memory read port and pixel stream bundled for the frame reader.
// master = reader side, slave = memory model / downstream consumer side.
interface framebuffer_reader_if #(
    parameter int DATA_W = 36
);
    logic [19:0]       mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] pix_data;
    logic [9:0]        pix_x;
    logic [8:0]        pix_y;
    logic              pix_last;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output mem_addr, mem_re, pix_data, pix_x, pix_y, pix_last, pix_valid,
        input  mem_data, pix_ready
    );

    modport slave (
        input  mem_addr, mem_re, pix_data, pix_x, pix_y, pix_last, pix_valid,
        output mem_data, pix_ready
    );
endinterface

// File: rtl/framebuffer_reader.sv
// Streams a WIDTH x HEIGHT frame out of fixed-latency memory in raster order,
// using an issued-read shift register and a credit-limited return FIFO.
module framebuffer_reader #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int DATA_W       = 36,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    framebuffer_reader_if.master  bus
);
    localparam int          NPIX      = WIDTH * HEIGHT;
    localparam logic [19:0] LAST_ADDR = 20'(NPIX - 1);
    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [19:0]             r_rd_addr;
    logic [READ_LATENCY-1:0] r_pipe;
    logic [READ_LATENCY-1:0] w_pipe_next;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [DATA_W-1:0]       r_mem [FIFO_DEPTH];
    logic [9:0]              r_x;
    logic [8:0]              r_y;
    logic                    r_done;

    logic                    w_valid;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_issue;
    logic                    w_last_pix;
    logic                    w_accept_start;
    logic [CW-1:0]           w_inflight;
    logic [CW-1:0]           w_occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_valid        = (r_count != '0);
    assign w_pop          = w_valid & bus.pix_ready;
    assign w_push         = r_pipe[READ_LATENCY-1];
    assign w_last_pix     = w_valid && (r_x == 10'(WIDTH - 1)) && (r_y == 9'(HEIGHT - 1));
    assign w_accept_start = (r_state == S_IDLE) && start;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_pipe[i]);
        end
    end

    // A read may issue only if its data is guaranteed a FIFO slot on return,
    // counting the slot freed by a pop in this same cycle.
    assign w_occupancy = r_count + w_inflight - CW'(w_pop);
    assign w_issue     = (r_state == S_FETCH) && (w_occupancy < CW'(FIFO_DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign w_pipe_next[gi] = w_issue;
            end else begin : g_tail
                assign w_pipe_next[gi] = r_pipe[gi-1];
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_FETCH;
            S_FETCH: if (w_issue && (r_rd_addr == LAST_ADDR)) w_state_next = S_DRAIN;
            S_DRAIN: if (w_pop && w_last_pix) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_pipe  <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_pop && w_last_pix;
            r_pipe  <= w_pipe_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr <= '0;
        end else if (w_accept_start) begin
            r_rd_addr <= '0;
        end else if (w_issue) begin
            r_rd_addr <= r_rd_addr + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.mem_data;
    end

    // Coordinates track the pixel currently at the FIFO head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_accept_start) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pop) begin
            if (r_x == 10'(WIDTH - 1)) begin
                r_x <= '0;
                r_y <= (r_y == 9'(HEIGHT - 1)) ? '0 : r_y + 9'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    assign bus.mem_re    = w_issue;
    assign bus.mem_addr  = r_rd_addr;
    assign bus.pix_valid = w_valid;
    assign bus.pix_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.pix_x     = r_x;
    assign bus.pix_y     = r_y;
    assign bus.pix_last  = w_last_pix;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
endmodule
